// File: rtl/dial_emulator.sv
`default_nettype none
// ============================================================================
// Module   : dial_emulator
// Brief    : Quadrature rotary-dial stimulus generator: rotates an emulated
//            dial to a target digit, then presses and releases its button.
// Revision : 1.0 - initial release
// ============================================================================
module dial_emulator #(
    parameter int STEP_TICKS  = 4,
    parameter int PRESS_TICKS = 8
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_digit,
    input  logic       cmd_dir,
    input  logic       abort,
    output logic [7:0] re_out,
    output logic [3:0] pos_out,
    output logic       busy,
    output logic       err
);

    localparam int MAX_TICKS = (STEP_TICKS > PRESS_TICKS) ? STEP_TICKS : PRESS_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_TICKS - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_PRESS  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       phase_q,  phase_d;
    logic [1:0]       ba_q,     ba_d;
    logic             press_q,  press_d;
    logic [3:0]       pos_q,    pos_d;
    logic [3:0]       target_q, target_d;
    logic             dir_q,    dir_d;
    logic             err_q,    err_d;
    logic [3:0]       pos_next;
    logic [1:0]       phase_inc;

    // Phase index 1..3 are the intermediate {B,A} codes; index 0 is the detent.
    function automatic logic [1:0] phase_ba(input logic [1:0] idx, input logic dir);
        logic [1:0] ba;
        case (idx)
            2'd1:    ba = dir ? 2'b10 : 2'b01;
            2'd2:    ba = 2'b11;
            2'd3:    ba = dir ? 2'b01 : 2'b10;
            default: ba = 2'b00;
        endcase
        return ba;
    endfunction

    always_comb begin
        if (dir_q) pos_next = (pos_q == 4'd0) ? 4'd9 : pos_q - 4'd1;
        else       pos_next = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
    end

    assign phase_inc = phase_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        ba_d     = ba_q;
        press_d  = press_q;
        pos_d    = pos_q;
        target_d = target_q;
        dir_d    = dir_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_digit > 4'd9) begin
                        err_d = 1'b1;
                    end else begin
                        target_d = cmd_digit;
                        dir_d    = cmd_dir;
                        cnt_d    = '0;
                        phase_d  = 2'd0;
                        ba_d     = 2'b00;
                        if (cmd_digit == pos_q) begin
                            state_d = ST_PRESS;
                            press_d = 1'b1;
                        end else begin
                            state_d = ST_ROTATE;
                        end
                    end
                end
            end
            ST_ROTATE: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d   = '0;
                    phase_d = phase_inc;
                    ba_d    = phase_ba(phase_inc, dir_q);
                    // Position only moves when the step returns to the detent.
                    if (phase_q == 2'd3) begin
                        pos_d = pos_next;
                        if (pos_next == target_q) begin
                            state_d = ST_PRESS;
                            press_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESS: begin
                if (cnt_q == PRESS_LAST) begin
                    cnt_d   = '0;
                    press_d = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == PRESS_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        // Cancel returns to the detent but keeps the last completed position.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phase_d = 2'd0;
            ba_d    = 2'b00;
            press_d = 1'b0;
            pos_d   = pos_q;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            phase_q  <= 2'd0;
            ba_q     <= 2'b00;
            press_q  <= 1'b0;
            pos_q    <= 4'd0;
            target_q <= 4'd0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ba_q     <= ba_d;
            press_q  <= press_d;
            pos_q    <= pos_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign re_out    = {5'b00000, press_q, ba_q};
    assign pos_out   = pos_q;
    assign err       = err_q;

endmodule
`default_nettype wire
